// File: rtl/uart_pkg.sv
// Shared types for the UART receive/transmit path: parity modes, receiver
// FSM states and the layout of a received-frame FIFO entry.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK_WAIT
    } rx_state_e;

    // Widest payload any receiver instance supports.
    localparam int MAX_DATA_BITS = 9;

    // FIFO entry width: payload plus frame-error and parity-error flags.
    function automatic int rx_entry_w(input int data_bits);
        return data_bits + 2;
    endfunction

    // Entry layout at maximum payload width; narrower receivers use the same
    // ordering {frame_err, parity_err, data} with a DATA_BITS-wide payload.
    typedef struct packed {
        logic                     frame_err;
        logic                     parity_err;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through synchronous FIFO. The head word is visible on
// data_o whenever the FIFO is non-empty and reads as zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver: synchronises rx_i, decodes start/data/parity/stop with
// mid-bit sampling, and queues {frame_err, parity_err, data} entries in a
// FWFT FIFO offered on a valid/ready stream. A held-low line yields a single
// break entry rather than a stream of phantom zero frames.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 868,
    parameter  int DATA_BITS    = 8,
    parameter  int PARITY       = 0,
    parameter  int STOP_BITS    = 1,
    parameter  int FIFO_DEPTH   = 16,
    parameter  int SYNC_STAGES  = 2,
    localparam int LW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_BITS-1:0] m_data_o,
    output logic                 m_frame_err_o,
    output logic                 m_parity_err_o,
    output logic                 overflow_o,
    input  logic                 clear_i,
    output logic [LW-1:0]        level_o,
    output logic                 busy_o
);

    localparam int EW = rx_entry_w(DATA_BITS);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;

    localparam logic [CW-1:0] HALF_LD   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LD   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [1:0]    PMODE_RAW = PARITY[1:0];
    localparam parity_e       PMODE     = parity_e'(PMODE_RAW);

    typedef struct packed {
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   overflow_q, overflow_d;
    logic                   push;
    logic                   cnt_zero;

    entry_t                 push_entry, head_entry;
    logic                   fifo_full, fifo_empty, pop;

    // Input synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign cnt_zero = (cnt_q == '0);

    // Receiver FSM next-state: every sample point is where the bit counter hits zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        push    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LD;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = FULL_LD;
                end
            end
            RX_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LD;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PMODE != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    perr_d  = (PMODE == PAR_ODD) ? ~(^shreg_q ^ rx_s) : (^shreg_q ^ rx_s);
                    cnt_d   = FULL_LD;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ferr_d = ferr_q | ~rx_s;
                    cnt_d  = FULL_LD;
                    if (bit_q == LAST_STOP) begin
                        push    = 1'b1;
                        state_d = (ferr_d && (shreg_q == '0) && !rx_s) ? RX_BREAK_WAIT : RX_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            RX_BREAK_WAIT: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver FSM registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // Last stop-bit sample is folded into the pushed entry directly.
    assign push_entry = '{frame_err: ferr_d, parity_err: perr_q, data: shreg_q};

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign m_valid_o      = ~fifo_empty;
    assign pop            = m_valid_o & m_ready_i;
    assign m_data_o       = head_entry.data;
    assign m_frame_err_o  = head_entry.frame_err;
    assign m_parity_err_o = head_entry.parity_err;
    assign busy_o         = (state_q != RX_IDLE);

    // Sticky overflow: a dropped frame wins over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop) overflow_d = 1'b1;
        else if (clear_i)              overflow_d = 1'b0;
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;

endmodule
